// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared definitions for the data-memory arbiter.
//   - arb_state_t and its three values IDLE, PEND, FORCE
//   - default address width, data width and starvation limit
package dmem_arb_pkg;

    // The states are plain constants so that older tools can read them too.
    typedef logic [1:0] arb_state_t;

    localparam arb_state_t IDLE  = 2'd0;  // no host request held
    localparam arb_state_t PEND  = 2'd1;  // host request held, waiting for a free cycle
    localparam arb_state_t FORCE = 2'd2;  // host served, core stalled

    localparam int unsigned AW_DEFAULT     = 8;
    localparam int unsigned DW_DEFAULT     = 8;
    localparam int unsigned STARVE_DEFAULT = 4;

    localparam int unsigned STARVE_CNT_W = 3;

endpackage

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between a core and a host.
// The core normally owns the memory. A host request is captured into a
// holding register and served in the first cycle the core leaves the memory
// idle. If the core keeps the memory busy for STARVE cycles in a row, the
// arbiter stalls the core for one cycle and serves the host then.
//
// Ports
//   clk, reset                  clock, synchronous active-high reset
//   core_rd_en/wr_en/addr/wdat  core access (rd+wr together counts as a write)
//   core_rdat                   core load data, straight from mem_rdat
//   core_stall                  core holds PC and request this cycle
//   host_req/we/addr/wdat       host request, sampled only while host_busy=0
//   host_busy                   request captured and not yet acknowledged
//   host_ack                    one-cycle completion pulse
//   host_rdat                   registered read data, valid with host_ack
//   mem_addr/wdat/wr_en         single-port memory command
//   mem_rdat                    combinational memory read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned AW     = AW_DEFAULT,
    parameter int unsigned DW     = DW_DEFAULT,
    parameter int unsigned STARVE = STARVE_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          core_rd_en,
    input  logic          core_wr_en,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdat,
    output logic [DW-1:0] core_rdat,
    output logic          core_stall,

    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdat,
    output logic          host_busy,
    output logic          host_ack,
    output logic [DW-1:0] host_rdat,

    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdat,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_rdat
);

    localparam logic [STARVE_CNT_W-1:0] StarveLim = STARVE_CNT_W'(STARVE);

    arb_state_t              state_q, state_d;
    logic [STARVE_CNT_W-1:0] starve_q, starve_d;

    // Held host request.
    logic                    hold_we_q, hold_we_d;
    logic [AW-1:0]           hold_addr_q, hold_addr_d;
    logic [DW-1:0]           hold_wdat_q, hold_wdat_d;

    logic                    ack_q, ack_d;
    logic [DW-1:0]           rdat_q, rdat_d;

    logic                    core_act;
    logic                    host_serve;
    logic                    mem_we_raw;

    assign core_act = core_rd_en | core_wr_en;

    always_comb begin
        state_d     = state_q;
        starve_d    = starve_q;
        hold_we_d   = hold_we_q;
        hold_addr_d = hold_addr_q;
        hold_wdat_d = hold_wdat_q;
        ack_d       = 1'b0;
        rdat_d      = rdat_q;
        host_serve  = 1'b0;

        // Idle memory keeps the held request on the bus so it stays stable.
        mem_addr    = hold_addr_q;
        mem_wdat    = hold_wdat_q;
        mem_we_raw  = 1'b0;

        case (state_q)
            IDLE: begin
                if (core_act) begin
                    mem_addr   = core_addr;
                    mem_wdat   = core_wdat;
                    mem_we_raw = core_wr_en;
                end
                if (host_req) begin
                    hold_we_d   = host_we;
                    hold_addr_d = host_addr;
                    hold_wdat_d = host_wdat;
                    state_d     = PEND;
                end
            end
            PEND: begin
                if (core_act) begin
                    mem_addr   = core_addr;
                    mem_wdat   = core_wdat;
                    mem_we_raw = core_wr_en;
                    starve_d   = starve_q + 1'b1;
                    if (starve_d == StarveLim) begin
                        state_d = FORCE;
                    end
                end else begin
                    host_serve = 1'b1;
                end
            end
            FORCE: begin
                host_serve = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (host_serve) begin
            mem_addr   = hold_addr_q;
            mem_wdat   = hold_wdat_q;
            mem_we_raw = hold_we_q;
            state_d    = IDLE;
            starve_d   = '0;
            ack_d      = 1'b1;
            if (!hold_we_q) begin
                rdat_d = mem_rdat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            hold_we_q   <= 1'b0;
            hold_addr_q <= '0;
            hold_wdat_q <= '0;
            ack_q       <= 1'b0;
            rdat_q      <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            hold_we_q   <= hold_we_d;
            hold_addr_q <= hold_addr_d;
            hold_wdat_q <= hold_wdat_d;
            ack_q       <= ack_d;
            rdat_q      <= rdat_d;
        end
    end

    // A held request discarded by reset must never reach the memory.
    assign mem_wr_en  = mem_we_raw & ~reset;

    assign core_rdat  = mem_rdat;
    assign core_stall = (state_q == FORCE);
    assign host_busy  = (state_q != IDLE);
    assign host_ack   = ack_q;
    assign host_rdat  = rdat_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: a default instance (STARVE=4) on a
// behavioural memory plus a read-only STARVE=1 instance sharing that memory.
// Host completions are checked against a scoreboard of expected host_rdat.
module tb_dmem_arbiter;

    logic       clk;
    logic       reset;
    logic       mem_init;

    logic       core_rd_en, core_wr_en;
    logic [7:0] core_addr, core_wdat, core_rdat;
    logic       core_stall;
    logic       host_req, host_we;
    logic [7:0] host_addr, host_wdat;
    logic       host_busy, host_ack;
    logic [7:0] host_rdat;
    logic [7:0] mem_addr, mem_wdat, mem_rdat;
    logic       mem_wr_en;

    logic       s_core_rd_en, s_core_wr_en;
    logic [7:0] s_core_addr, s_core_wdat, s_core_rdat;
    logic       s_core_stall;
    logic       s_host_req, s_host_we;
    logic [7:0] s_host_addr, s_host_wdat;
    logic       s_host_busy, s_host_ack;
    logic [7:0] s_host_rdat;
    logic [7:0] s_mem_addr, s_mem_wdat, s_mem_rdat;
    logic       s_mem_wr_en;

    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];
    logic [7:0] sb_q    [$];
    logic [7:0] last_rd;
    logic [7:0] mon_exp;
    int         checks;
    int         errors;

    dmem_arbiter u_dut (
        .clk        (clk),
        .reset      (reset),
        .core_rd_en (core_rd_en),
        .core_wr_en (core_wr_en),
        .core_addr  (core_addr),
        .core_wdat  (core_wdat),
        .core_rdat  (core_rdat),
        .core_stall (core_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdat  (host_wdat),
        .host_busy  (host_busy),
        .host_ack   (host_ack),
        .host_rdat  (host_rdat),
        .mem_addr   (mem_addr),
        .mem_wdat   (mem_wdat),
        .mem_wr_en  (mem_wr_en),
        .mem_rdat   (mem_rdat)
    );

    dmem_arbiter #(
        .STARVE (1)
    ) u_dut_s1 (
        .clk        (clk),
        .reset      (reset),
        .core_rd_en (s_core_rd_en),
        .core_wr_en (s_core_wr_en),
        .core_addr  (s_core_addr),
        .core_wdat  (s_core_wdat),
        .core_rdat  (s_core_rdat),
        .core_stall (s_core_stall),
        .host_req   (s_host_req),
        .host_we    (s_host_we),
        .host_addr  (s_host_addr),
        .host_wdat  (s_host_wdat),
        .host_busy  (s_host_busy),
        .host_ack   (s_host_ack),
        .host_rdat  (s_host_rdat),
        .mem_addr   (s_mem_addr),
        .mem_wdat   (s_mem_wdat),
        .mem_wr_en  (s_mem_wr_en),
        .mem_rdat   (s_mem_rdat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port memory written only by the default instance.
    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i * 7 + 3);
        end else if (mem_wr_en) begin
            mem[mem_addr] <= mem_wdat;
        end
    end
    assign mem_rdat   = mem[mem_addr];
    assign s_mem_rdat = mem[s_mem_addr];

    // Scoreboard: each host completion pops the value host_rdat must show.
    always @(negedge clk) begin
        if (host_ack === 1'b1) begin
            checks++;
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected_ack: host_ack=1 with no outstanding request");
            end else begin
                mon_exp = sb_q.pop_front();
                if (host_rdat !== mon_exp) begin
                    errors++;
                    $display("FAIL sb_host_rdat: got %h expected %h", host_rdat, mon_exp);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic host_drive(input logic we, input logic [7:0] a, input logic [7:0] d);
        host_req  = 1'b1;
        host_we   = we;
        host_addr = a;
        host_wdat = d;
    endtask

    // Record what the bench expects once a request is known to be captured.
    task automatic sb_expect(input logic we, input logic [7:0] a, input logic [7:0] d);
        if (we) begin
            ref_mem[a] = d;
        end else begin
            last_rd = ref_mem[a];
        end
        sb_q.push_back(last_rd);
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        mem_init = 1'b1;
        tick();
        tick();
        reset    = 1'b0;
        mem_init = 1'b0;
        #1;
        checks += 6;
        if (host_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b expected 0", host_busy); end
        if (host_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %b expected 0", host_ack); end
        if (host_rdat !== 8'h00) begin errors++; $display("FAIL rst_rdat: got %h expected 00", host_rdat); end
        if (core_stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %b expected 0", core_stall); end
        if (mem_wr_en !== 1'b0) begin errors++; $display("FAIL rst_wr_en: got %b expected 0", mem_wr_en); end
        if (mem_addr !== 8'h00 || mem_wdat !== 8'h00) begin
            errors++;
            $display("FAIL rst_hold: got addr %h wdat %h expected 00 00", mem_addr, mem_wdat);
        end
        tick();
    endtask

    task automatic test_host_write_read();
        host_drive(1'b1, 8'h10, 8'h5A);
        sb_expect(1'b1, 8'h10, 8'h5A);
        tick();
        host_req = 1'b0;
        #1;
        checks += 2;
        if (mem_wr_en !== 1'b1 || mem_addr !== 8'h10 || mem_wdat !== 8'h5A) begin
            errors++;
            $display("FAIL hw_mem_cmd: got we %b addr %h wdat %h expected 1 10 5a",
                     mem_wr_en, mem_addr, mem_wdat);
        end
        if (host_busy !== 1'b1) begin errors++; $display("FAIL hw_busy: got %b expected 1", host_busy); end
        tick();
        #1;
        checks++;
        if (host_ack !== 1'b1 || host_busy !== 1'b0) begin
            errors++;
            $display("FAIL hw_ack: got ack %b busy %b expected 1 0", host_ack, host_busy);
        end
        host_drive(1'b0, 8'h10, 8'h00);
        sb_expect(1'b0, 8'h10, 8'h00);
        tick();
        host_req = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0 || mem_addr !== 8'h10) begin
            errors++;
            $display("FAIL hr_mem_cmd: got we %b addr %h expected 0 10", mem_wr_en, mem_addr);
        end
        tick();
        #1;
        checks++;
        if (host_ack !== 1'b1 || host_rdat !== 8'h5A) begin
            errors++;
            $display("FAIL hr_result: got ack %b rdat %h expected 1 5a", host_ack, host_rdat);
        end
        tick();
    endtask

    // Two rounds: the second only matches if the counter restarted from zero.
    task automatic test_starvation();
        for (int r = 0; r < 2; r++) begin
            core_rd_en = 1'b1;
            core_addr  = 8'h05;
            host_drive(1'b0, 8'h20, 8'h00);
            sb_expect(1'b0, 8'h20, 8'h00);
            tick();
            host_req = 1'b0;
            for (int i = 1; i <= 4; i++) begin
                #1;
                checks += 2;
                if (core_stall !== 1'b0) begin
                    errors++;
                    $display("FAIL starve_nostall_r%0d_c%0d: got %b expected 0", r, i, core_stall);
                end
                if (mem_addr !== 8'h05 || core_rdat !== ref_mem[5]) begin
                    errors++;
                    $display("FAIL starve_core_r%0d_c%0d: got addr %h rdat %h expected 05 %h",
                             r, i, mem_addr, core_rdat, ref_mem[5]);
                end
                tick();
            end
            #1;
            checks++;
            if (core_stall !== 1'b1 || mem_addr !== 8'h20 || mem_wr_en !== 1'b0) begin
                errors++;
                $display("FAIL starve_force_r%0d: got stall %b addr %h we %b expected 1 20 0",
                         r, core_stall, mem_addr, mem_wr_en);
            end
            tick();
            #1;
            checks++;
            if (host_ack !== 1'b1 || core_stall !== 1'b0) begin
                errors++;
                $display("FAIL starve_ack_r%0d: got ack %b stall %b expected 1 0",
                         r, host_ack, core_stall);
            end
            core_rd_en = 1'b0;
            tick();
        end
    endtask

    task automatic test_collision();
        core_wr_en = 1'b1;
        core_addr  = 8'h08;
        core_wdat  = 8'h33;
        host_drive(1'b1, 8'h08, 8'h44);
        sb_expect(1'b1, 8'h08, 8'h44);
        #1;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_addr !== 8'h08 || mem_wdat !== 8'h33) begin
            errors++;
            $display("FAIL coll_core_cycle: got we %b addr %h wdat %h expected 1 08 33",
                     mem_wr_en, mem_addr, mem_wdat);
        end
        tick();
        core_wr_en = 1'b0;
        host_req   = 1'b0;
        #1;
        checks++;
        if (mem_wr_en !== 1'b1 || mem_wdat !== 8'h44) begin
            errors++;
            $display("FAIL coll_host_cycle: got we %b wdat %h expected 1 44", mem_wr_en, mem_wdat);
        end
        tick();
        tick();
        checks++;
        if (mem[8] !== 8'h44) begin
            errors++;
            $display("FAIL coll_final: got %h expected 44", mem[8]);
        end
        host_drive(1'b0, 8'h08, 8'h00);
        sb_expect(1'b0, 8'h08, 8'h00);
        tick();
        host_req = 1'b0;
        tick();
        tick();
    endtask

    task automatic test_rd_wr_both();
        core_rd_en = 1'b1;
        core_wr_en = 1'b1;
        core_addr  = 8'h50;
        core_wdat  = 8'h66;
        #1;
        checks++;
        if (mem_wr_en !== 1'b1) begin
            errors++;
            $display("FAIL rdwr_we: got %b expected 1", mem_wr_en);
        end
        tick();
        core_rd_en = 1'b0;
        core_wr_en = 1'b0;
        ref_mem[8'h50] = 8'h66;
        checks++;
        if (mem[8'h50] !== 8'h66) begin
            errors++;
            $display("FAIL rdwr_mem: got %h expected 66", mem[8'h50]);
        end
        tick();
    endtask

    // host_req stays high: captures land on cycles 0, 2 and 4 only.
    task automatic test_back_to_back();
        logic exp_busy, exp_ack;
        for (int k = 0; k < 6; k++) begin
            host_drive(1'b1, 8'(8'h40 + k), 8'(8'h80 + k));
            exp_busy = (k % 2 == 1);
            exp_ack  = (k >= 2) && (k % 2 == 0);
            #1;
            checks++;
            if (host_busy !== exp_busy || host_ack !== exp_ack) begin
                errors++;
                $display("FAIL b2b_c%0d: got busy %b ack %b expected %b %b",
                         k, host_busy, host_ack, exp_busy, exp_ack);
            end
            if (!exp_busy) sb_expect(1'b1, 8'(8'h40 + k), 8'(8'h80 + k));
            tick();
        end
        host_req = 1'b0;
        #1;
        checks++;
        if (host_ack !== 1'b1) begin
            errors++;
            $display("FAIL b2b_last_ack: got %b expected 1", host_ack);
        end
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (mem[8'(8'h40 + k)] !== ref_mem[8'(8'h40 + k)]) begin
                errors++;
                $display("FAIL b2b_mem_%0d: got %h expected %h",
                         k, mem[8'(8'h40 + k)], ref_mem[8'(8'h40 + k)]);
            end
        end
    endtask

    task automatic test_reset_in_pend();
        host_drive(1'b1, 8'h30, 8'h77);
        tick();
        host_req = 1'b0;
        reset    = 1'b1;
        #1;
        checks++;
        if (mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rp_no_write: got %b expected 0", mem_wr_en);
        end
        tick();
        reset = 1'b0;
        #1;
        checks++;
        if (host_busy !== 1'b0 || host_ack !== 1'b0) begin
            errors++;
            $display("FAIL rp_after: got busy %b ack %b expected 0 0", host_busy, host_ack);
        end
        last_rd = 8'h00;
        tick();
        #1;
        checks += 2;
        if (host_ack !== 1'b0 || mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL rp_late: got ack %b we %b expected 0 0", host_ack, mem_wr_en);
        end
        if (mem[8'h30] !== ref_mem[8'h30]) begin
            errors++;
            $display("FAIL rp_mem: got %h expected %h", mem[8'h30], ref_mem[8'h30]);
        end
        tick();
    endtask

    task automatic test_starve_one();
        s_core_rd_en = 1'b1;
        s_core_addr  = 8'h07;
        s_host_req   = 1'b1;
        s_host_addr  = 8'h20;
        tick();
        s_host_req = 1'b0;
        #1;
        checks++;
        if (s_core_stall !== 1'b0 || s_mem_addr !== 8'h07) begin
            errors++;
            $display("FAIL s1_first: got stall %b addr %h expected 0 07", s_core_stall, s_mem_addr);
        end
        tick();
        #1;
        checks++;
        if (s_core_stall !== 1'b1 || s_mem_addr !== 8'h20 || s_mem_wr_en !== 1'b0) begin
            errors++;
            $display("FAIL s1_force: got stall %b addr %h we %b expected 1 20 0",
                     s_core_stall, s_mem_addr, s_mem_wr_en);
        end
        tick();
        #1;
        checks++;
        if (s_host_ack !== 1'b1 || s_host_rdat !== ref_mem[8'h20] || s_core_stall !== 1'b0) begin
            errors++;
            $display("FAIL s1_ack: got ack %b rdat %h stall %b expected 1 %h 0",
                     s_host_ack, s_host_rdat, s_core_stall, ref_mem[8'h20]);
        end
        s_core_rd_en = 1'b0;
        tick();
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        last_rd      = 8'h00;
        reset        = 1'b1;
        mem_init     = 1'b1;
        core_rd_en   = 1'b0;
        core_wr_en   = 1'b0;
        core_addr    = 8'h00;
        core_wdat    = 8'h00;
        host_req     = 1'b0;
        host_we      = 1'b0;
        host_addr    = 8'h00;
        host_wdat    = 8'h00;
        s_core_rd_en = 1'b0;
        s_core_wr_en = 1'b0;
        s_core_addr  = 8'h00;
        s_core_wdat  = 8'h00;
        s_host_req   = 1'b0;
        s_host_we    = 1'b0;
        s_host_addr  = 8'h00;
        s_host_wdat  = 8'h00;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i * 7 + 3);

        test_reset();
        test_host_write_read();
        test_starvation();
        test_collision();
        test_rd_wr_both();
        test_back_to_back();
        test_reset_in_pend();
        test_starve_one();

        tick();
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover: got %0d outstanding expected 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
